rib_mem_bridge: RTL
===================

Name: rib_mem_bridge

Overview:
- Adapts the tinyriscv RIB data master (rib_ex_* ports, with hold) to the Controller's data-memory bus (core_*_memory_data ports).
- Sits between the core's execute-stage bus port and the Controller in processorci_top.
- Converts the core's same-cycle read expectation into a level request / response handshake, stalling the core via hold while an access is outstanding.
- Also counts completed reads and writes for debug readout.

Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides
- TIMEOUT_CYCLES, 1024, BUSY cycles before abort; used only with RESP_TIMEOUT_EN
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk  in  1  core clock (clk_core)
- rst_n  in  1  asynchronous active-low reset
- rib_addr_i  in  ADDR_WIDTH  core access address
- rib_data_i  in  DATA_WIDTH  core write data
- rib_req_i  in  1  core access request
- rib_we_i  in  1  1 = write, 0 = read
- rib_data_o  out  DATA_WIDTH  read data to core
- rib_hold_o  out  1  stall core pipeline
- mem_read_o  out  1  read request (level)
- mem_write_o  out  1  write request (level)
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid with response
- mem_response_i  in  1  one-cycle completion pulse
- rd_count_o  out  32  completed reads, wraps
- wr_count_o  out  32  completed writes, wraps
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All registered outputs = 0: mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o, rd_count_o, wr_count_o, err_o, and the read-data capture register.
  - Reset mid-access drops the request immediately; any later mem_response_i is ignored.
- FSM states: IDLE, BUSY, DONE (ERR path only with RESP_TIMEOUT_EN).
- IDLE:
  - rib_hold_o = rib_req_i (combinational), so the core stalls in the same cycle it requests.
  - On rib_req_i: latch addr, wdata and we; set mem_read_o = !we or mem_write_o = we; go BUSY.
- BUSY:
  - rib_hold_o = 1; request lines and addr/wdata held stable.
  - On mem_response_i: capture mem_rdata_i (reads only); clear request lines next edge; increment rd_count_o or wr_count_o; go DONE.
  - A response in the first BUSY cycle is legal.
- DONE:
  - rib_hold_o = 0; rib_data_o = captured data; core retires the access this cycle.
  - Next state is IDLE unconditionally. rib_req_i is not sampled in DONE: the core's request in DONE belongs to the access being retired.
- rib_data_o = 0 in every state other than DONE.
- Latency:
  - Response in first BUSY cycle: hold high 2 cycles, data to core on the 3rd.
  - In general: hold high (1 + response delay) cycles.
- Writes are non-posted: they complete only on mem_response_i.
- mem_response_i outside BUSY is ignored (no count, no capture).
- Back-to-back accesses: a new request is seen in the IDLE cycle right after DONE; minimum spacing is one IDLE cycle between accesses.
- Counters wrap 32'hFFFF_FFFF -> 0.

Optional Feature:
- Macro: RESP_TIMEOUT_EN
- Defined:
  - A cycle counter runs in BUSY.
  - When it reaches TIMEOUT_CYCLES with no response: drop the request, set err_o (sticky until reset), go DONE with rib_data_o = TIMEOUT_DATA for reads. No counter increments.
  - A response arriving in the same cycle as the timeout wins: normal completion.
- Undefined: BUSY waits indefinitely; err_o tied to 0; no timeout counter logic.

Decomposition:
- Shared package processorci_bus_pkg:
  - FSM state encoding (IDLE = 0, BUSY = 1, DONE = 2).
  - TIMEOUT_DATA default constant.
  - Bus width constants.
- No sub-module required. The FSM, capture registers and counters fit in one module (~150–250 lines).

Test Plan:
- Read, response 1 cycle after issue, mem_rdata_i = 32'h1234_5678 -> hold high 2 cycles, rib_data_o = 32'h1234_5678 in DONE only, rd_count_o = 1.
- Write addr 32'h0000_0100, data 32'hCAFE_F00D, response after 5 cycles -> mem_write_o high exactly until the response, addr/wdata stable throughout, wr_count_o = 1, rib_data_o stays 0.
- Two back-to-back reads (second request right after DONE) -> exactly two read requests issued, one IDLE cycle between them, rd_count_o = 2.
- Spurious mem_response_i pulses in IDLE and DONE -> no state change, counters unchanged.
- rst_n asserted mid-BUSY, then response pulse after release -> outputs 0 immediately, late response ignored, state IDLE.
- With RESP_TIMEOUT_EN, TIMEOUT_CYCLES = 8, read with no response -> hold drops after timeout, rib_data_o = 32'hDEAD_BEEF, err_o = 1 and stays set, rd_count_o = 0.

Source files
------------

// File: rtl/processorci_bus_pkg.sv
// Shared definitions for the processorci data-memory bus: widths, the bridge
// FSM encoding and the default read data returned on a response timeout.
package processorci_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/rib_mem_bridge.sv
// Bridges the tinyriscv RIB data master to the Controller's level request /
// pulse response data-memory bus. Optional response timeout: RESP_TIMEOUT_EN.
module rib_mem_bridge
  import processorci_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH     = BUS_ADDR_W,
  parameter int          DATA_WIDTH     = BUS_DATA_W,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rib_addr_i,
  input  logic [DATA_WIDTH-1:0] rib_data_i,
  input  logic                  rib_req_i,
  input  logic                  rib_we_i,
  output logic [DATA_WIDTH-1:0] rib_data_o,
  output logic                  rib_hold_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_response_i,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: mem_read_o / mem_write_o are levels held from issue until the
  // edge after mem_response_i (a single-cycle pulse, honoured only in BUSY).
  bridge_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           wr_cnt_q;

`ifdef RESP_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q;
  logic        err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{32'(TIMEOUT_CYCLES), TIMEOUT_DATA};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
`ifdef RESP_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rib_req_i) begin
            addr_q  <= rib_addr_i;
            wdata_q <= rib_data_i;
            we_q    <= rib_we_i;
            rd_q    <= !rib_we_i;
            wr_q    <= rib_we_i;
            state_q <= ST_BUSY;
`ifdef RESP_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (mem_response_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_DONE;
            if (!we_q) begin
              rdata_q  <= mem_rdata_i;
              rd_cnt_q <= rd_cnt_q + 32'd1;
            end else begin
              wr_cnt_q <= wr_cnt_q + 32'd1;
            end
`ifdef RESP_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            // Abandon the access; the core still retires it through DONE.
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
            if (!we_q) rdata_q <= DATA_WIDTH'(TIMEOUT_DATA);
          end else begin
            tmo_q <= tmo_q + 32'd1;
`endif
          end
        end
        // rib_req_i seen here still belongs to the access being retired.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rib_hold_o = 1'b0;
    case (state_q)
      ST_IDLE: rib_hold_o = rib_req_i;
      ST_BUSY: rib_hold_o = 1'b1;
      default: rib_hold_o = 1'b0;
    endcase
  end

  assign rib_data_o  = (state_q == ST_DONE && !we_q) ? rdata_q : '0;
  assign mem_read_o  = rd_q;
  assign mem_write_o = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign dbg_state_o = state_q;

`ifdef RESP_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
